// File: rtl/noc_pkg.sv
// Shared router definitions: output-VC state encoding, port direction indices
// and the bit positions of the tracker's error flags.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } ovc_state_e;

  localparam int N_EAST  = 0;
  localparam int N_NORTH = 1;
  localparam int N_WEST  = 2;
  localparam int N_SOUTH = 3;
  localparam int N_EXIT  = 4;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_PROTOCOL  = 2;

  // Flat OVC index used throughout the router.
  function automatic int ovc_index(input int port, input int vc, input int channels);
    return port * channels + vc;
  endfunction

endpackage

// File: rtl/ovc_slot.sv
// One output VC: ownership FSM plus downstream credit counter.
// Per-cycle error events are exported only when OVC_ERR_EN is defined.
module ovc_slot
  import noc_pkg::*;
#(
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_BITS     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_alloc,
  input  logic i_sent,
  input  logic i_tail,
  input  logic i_credit,
  output logic o_idle,
  output logic o_credit_avail
`ifdef OVC_ERR_EN
  ,
  output logic [2:0] o_err
`endif
);

  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(CREDIT_DEPTH);
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  ovc_state_e r_state;
  ovc_state_e w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic w_full;
  logic w_empty;

  assign w_full  = (r_cnt == FULL);
  assign w_empty = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= FULL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Send and credit in the same cycle cancel; out-of-range moves saturate.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_sent && !i_credit && !w_empty) begin
      w_cnt_nxt = r_cnt - ONE;
    end else if (i_credit && !i_sent && !w_full) begin
      w_cnt_nxt = r_cnt + ONE;
    end
  end

  // DRAIN leaves on the registered count, so the release lands one cycle
  // after the final credit arrives.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_alloc) w_state_nxt = ACTIVE;
      ACTIVE:  if (i_sent && i_tail) w_state_nxt = DRAIN;
      DRAIN:   if (w_full) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_idle         = (r_state == IDLE);
  assign o_credit_avail = !w_empty;

`ifdef OVC_ERR_EN
  logic w_underflow;
  logic w_overflow;
  logic w_protocol;

  assign w_underflow = i_sent && !i_credit && w_empty;
  assign w_overflow  = i_credit && !i_sent && w_full;
  assign w_protocol  = (i_alloc && (r_state != IDLE)) ||
                       (i_sent && (r_state != ACTIVE));

  always_comb begin
    o_err                = '0;
    o_err[ERR_UNDERFLOW] = w_underflow;
    o_err[ERR_OVERFLOW]  = w_overflow;
    o_err[ERR_PROTOCOL]  = w_protocol;
  end
`endif

endmodule

// File: rtl/ovc_state_tracker.sv
// Tracks ownership and downstream credits for every output VC of a router.
// Define OVC_ERR_EN to build the sticky error flags; otherwise err reads 0.
module ovc_state_tracker
  import noc_pkg::*;
#(
  parameter  int PORTS        = 5,
  parameter  int CHANNELS     = 12,
  parameter  int CREDIT_DEPTH = 4,
  localparam int NUM_OVC      = PORTS * CHANNELS,
  localparam int CNT_BITS     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_OVC-1:0] alloc_ovc,
  input  logic [NUM_OVC-1:0] flit_sent,
  input  logic [NUM_OVC-1:0] flit_tail,
  input  logic [NUM_OVC-1:0] credit_in,
  output logic [NUM_OVC-1:0] ovid_avail,
  output logic [NUM_OVC-1:0] credit_avail,
  output logic [2:0]         err
);

`ifdef OVC_ERR_EN
  logic [2:0] w_slot_err [NUM_OVC];
  logic [2:0] w_err_any;
  logic [2:0] r_err;
`endif

  for (genvar g = 0; g < NUM_OVC; g++) begin : g_slot
    ovc_slot #(
      .CREDIT_DEPTH (CREDIT_DEPTH),
      .CNT_BITS     (CNT_BITS)
    ) u_slot (
      .clk            (clk),
      .rst            (rst),
      .i_alloc        (alloc_ovc[g]),
      .i_sent         (flit_sent[g]),
      .i_tail         (flit_tail[g]),
      .i_credit       (credit_in[g]),
      .o_idle         (ovid_avail[g]),
      .o_credit_avail (credit_avail[g])
`ifdef OVC_ERR_EN
      ,
      .o_err          (w_slot_err[g])
`endif
    );
  end

`ifdef OVC_ERR_EN
  always_comb begin
    w_err_any = '0;
    for (int i = 0; i < NUM_OVC; i++) begin
      w_err_any = w_err_any | w_slot_err[i];
    end
  end

  // Flags accumulate until the next reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | w_err_any;
    end
  end

  assign err = r_err;
`else
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_ovc_state_tracker.sv
// Directed plus randomized bench for ovc_state_tracker against a per-OVC
// behavioural model; error-flag expectations follow OVC_ERR_EN.
module tb_ovc_state_tracker;

  localparam int N = 60;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] alloc_ovc, flit_sent, flit_tail, credit_in;
  logic [N-1:0] ovid_avail, credit_avail;
  logic [2:0]   err;

  always #5 clk = ~clk;

  ovc_state_tracker #(
    .PORTS        (5),
    .CHANNELS     (12),
    .CREDIT_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_ovc    (alloc_ovc),
    .flit_sent    (flit_sent),
    .flit_tail    (flit_tail),
    .credit_in    (credit_in),
    .ovid_avail   (ovid_avail),
    .credit_avail (credit_avail),
    .err          (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owned = allocated and not yet released; tail_done = tail sent,
  // waiting for all credits to come home.
  bit         m_owned     [N];
  bit         m_tail_done [N];
  int         m_cnt       [N];
  logic [2:0] m_err;

  logic [N-1:0] Z;
  logic [N-1:0] ONES;

  function automatic logic [N-1:0] bitv(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ovid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = !m_owned[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_credit();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  function automatic logic [2:0] exp_err();
`ifdef OVC_ERR_EN
    return m_err;
`else
    return 3'b000;
`endif
  endfunction

  task automatic model(input logic r, input logic [N-1:0] a, s, t, c);
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        m_owned[i] = 0; m_tail_done[i] = 0; m_cnt[i] = D;
      end
      m_err = 3'b000;
      return;
    end
    for (int i = 0; i < N; i++) begin
      int  raw;
      bit  all_home;
      all_home = (m_cnt[i] == D);
      raw = m_cnt[i] - (s[i] ? 1 : 0) + (c[i] ? 1 : 0);
      if (raw < 0) begin m_err[0] = 1'b1; raw = 0; end
      if (raw > D) begin m_err[1] = 1'b1; raw = D; end
      if (!m_owned[i]) begin
        if (s[i]) m_err[2] = 1'b1;
        if (a[i]) m_owned[i] = 1;
      end else if (!m_tail_done[i]) begin
        if (a[i]) m_err[2] = 1'b1;
        if (s[i] && t[i]) m_tail_done[i] = 1;
      end else begin
        if (a[i] || s[i]) m_err[2] = 1'b1;
        if (all_home) begin m_owned[i] = 0; m_tail_done[i] = 0; end
      end
      m_cnt[i] = raw;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] a, s, t, c, input string tag);
    rst = r; alloc_ovc = a; flit_sent = s; flit_tail = t; credit_in = c;
    @(posedge clk);
    model(r, a, s, t, c);
    #1;
    chk({tag, ":ovid"},   64'(ovid_avail),   64'(exp_ovid()));
    chk({tag, ":credit"}, 64'(credit_avail), 64'(exp_credit()));
    chk({tag, ":err"},    64'(err),          64'(exp_err()));
  endtask

  task automatic idle(input string tag);
    step(1'b1, Z, Z, Z, Z, tag);
  endtask

  initial begin
    Z = '0;
    ONES = '1;
    for (int i = 0; i < N; i++) begin
      m_owned[i] = 0; m_tail_done[i] = 0; m_cnt[i] = D;
    end
    m_err = 3'b000;

    // Reset state
    step(1'b0, Z, Z, Z, Z, "rst0");
    step(1'b0, Z, Z, Z, Z, "rst1");
    chk("rst_ovid_all",   64'(ovid_avail),   64'(ONES));
    chk("rst_credit_all", 64'(credit_avail), 64'(ONES));
    chk("rst_err",        64'(err),          64'(0));

    // Reset mid-packet on OVC 7 overrides all inputs
    step(1'b1, bitv(7), Z, Z, Z, "o7_alloc");
    step(1'b1, Z, bitv(7), Z, Z, "o7_send0");
    step(1'b1, Z, bitv(7), Z, Z, "o7_send1");
    chk("o7_busy", 64'(ovid_avail[7]), 64'(0));
    step(1'b0, bitv(7), bitv(7), bitv(7), bitv(7), "o7_rst");
    chk("o7_idle_after_rst",  64'(ovid_avail[7]),   64'(1));
    chk("o7_credit_after_rst", 64'(credit_avail[7]), 64'(1));
    idle("o7_post");

    // OVC 13: 4-flit packet, then credits trickle back
    step(1'b1, bitv(13), Z, Z, Z, "o13_alloc");
    chk("o13_busy_next", 64'(ovid_avail[13]), 64'(0));
    step(1'b1, Z, bitv(13), Z, Z, "o13_s1");
    step(1'b1, Z, bitv(13), Z, Z, "o13_s2");
    step(1'b1, Z, bitv(13), Z, Z, "o13_s3");
    chk("o13_credit_before_last", 64'(credit_avail[13]), 64'(1));
    step(1'b1, Z, bitv(13), bitv(13), Z, "o13_s4_tail");
    chk("o13_credit_empty", 64'(credit_avail[13]), 64'(0));
    idle("o13_drain");
    chk("o13_drain_busy", 64'(ovid_avail[13]), 64'(0));
    step(1'b1, Z, Z, Z, bitv(13), "o13_c1");
    chk("o13_credit_back", 64'(credit_avail[13]), 64'(1));
    step(1'b1, Z, Z, Z, bitv(13), "o13_c2");
    step(1'b1, Z, Z, Z, bitv(13), "o13_c3");
    step(1'b1, Z, Z, Z, bitv(13), "o13_c4");
    chk("o13_still_busy_on_last_credit", 64'(ovid_avail[13]), 64'(0));
    idle("o13_release");
    chk("o13_released", 64'(ovid_avail[13]), 64'(1));
    chk("o13_no_err", 64'(err), 64'(0));

    // OVC 0: concurrent send and credit at count 2 leaves the count alone
    step(1'b1, bitv(0), Z, Z, Z, "o0_alloc");
    step(1'b1, Z, bitv(0), Z, Z, "o0_s1");
    step(1'b1, Z, bitv(0), Z, Z, "o0_s2");
    for (int k = 0; k < 5; k++) begin
      step(1'b1, Z, bitv(0), Z, bitv(0), "o0_both");
      chk("o0_credit_hold", 64'(credit_avail[0]), 64'(1));
    end
    step(1'b1, Z, bitv(0), Z, Z, "o0_s3");
    chk("o0_one_left", 64'(credit_avail[0]), 64'(1));
    step(1'b1, Z, bitv(0), bitv(0), Z, "o0_s4_tail");
    chk("o0_empty_after_two", 64'(credit_avail[0]), 64'(0));
    for (int k = 0; k < 4; k++) step(1'b1, Z, Z, Z, bitv(0), "o0_cret");
    idle("o0_release");
    chk("o0_released", 64'(ovid_avail[0]), 64'(1));

    // Error flags
    step(1'b0, Z, Z, Z, Z, "e_rst");
    step(1'b1, bitv(2), Z, Z, Z, "e_alloc2");
    for (int k = 0; k < 4; k++) step(1'b1, Z, bitv(2), Z, Z, "e_drain2");
    step(1'b1, Z, bitv(2), bitv(2), Z, "e_underflow");
    chk("e_cnt_held_zero", 64'(credit_avail[2]), 64'(0));
`ifdef OVC_ERR_EN
    chk("e_underflow_flag", 64'(err), 64'(3'b001));
`else
    chk("e_underflow_noflag", 64'(err), 64'(0));
`endif
    step(1'b1, Z, Z, Z, bitv(3), "e_overflow");
    chk("e_cnt_saturated", 64'(credit_avail[3]), 64'(1));
`ifdef OVC_ERR_EN
    chk("e_overflow_flag", 64'(err), 64'(3'b011));
`else
    chk("e_overflow_noflag", 64'(err), 64'(0));
`endif
    step(1'b1, bitv(5), Z, Z, Z, "e_alloc5");
    step(1'b1, bitv(5), Z, Z, Z, "e_realloc5");
    chk("e_o5_still_busy", 64'(ovid_avail[5]), 64'(0));
    for (int k = 0; k < 3; k++) idle("e_sticky");
`ifdef OVC_ERR_EN
    chk("e_all_sticky", 64'(err), 64'(3'b111));
`else
    chk("e_none", 64'(err), 64'(0));
`endif
    step(1'b0, Z, Z, Z, Z, "e_clear");
    chk("e_cleared", 64'(err), 64'(0));

    // OVC 59: single-flit packet
    step(1'b1, bitv(59), Z, Z, Z, "o59_alloc");
    step(1'b1, Z, bitv(59), bitv(59), Z, "o59_headtail");
    chk("o59_busy", 64'(ovid_avail[59]), 64'(0));
    idle("o59_wait");
    step(1'b1, Z, Z, Z, bitv(59), "o59_credit");
    chk("o59_busy_on_credit", 64'(ovid_avail[59]), 64'(0));
    idle("o59_release");
    chk("o59_released", 64'(ovid_avail[59]), 64'(1));

    // Randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [N-1:0] a, s, t, c;
      logic r;
      r = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 11) == 0);
        s[i] = ($urandom_range(0, 5) == 0);
        t[i] = ($urandom_range(0, 1) == 0);
        c[i] = ($urandom_range(0, 5) == 0);
      end
      step(r, a, s, t, c, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
